cache_ctrl_wb: RTL and testbench

CACHE_CTRL_WB -- requirements
Module: cache_ctrl_wb

---
 rtl/cache_ctrl_wb.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_cache_ctrl_wb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_wb.sv
// rtl/cache_ctrl_wb.sv - direct-mapped write-back, write-allocate cache controller
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.

module cache_ctrl_wb #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_LINES      = 256,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   input  logic                  cpu_read_enable,
   input  logic                  cpu_write_enable,
   input  logic [DATA_WIDTH-1:0] cpu_write_data,
   output logic [DATA_WIDTH-1:0] cpu_read_data,
   output logic                  cpu_ready,
   input  logic                  flush_request,
   output logic                  flush_done,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read_enable,
   output logic                  mem_write_enable,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
`ifdef CACHE_STATS_EN
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count,
`endif
   input  logic                  mem_ack
);

   localparam int BO = $clog2(DATA_WIDTH / 8);
   localparam int WO = $clog2(WORDS_PER_LINE);
   localparam int IX = $clog2(NUM_LINES);
   localparam int TW = ADDR_WIDTH - IX - WO - BO;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COMPARE,
      S_WRITEBACK,
      S_REFILL,
      S_FLUSH
   } state_t;

   state_t                state_q, state_d;
   logic [WO-1:0]         word_cnt_q, word_cnt_d;
   logic [IX-1:0]         flush_idx_q, flush_idx_d;
   logic                  flush_mode_q, flush_mode_d;
   logic [NUM_LINES-1:0]  valid_q, valid_d;
   logic [NUM_LINES-1:0]  dirty_q, dirty_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic [TW-1:0]         tag_mem  [NUM_LINES];
   logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*WORDS_PER_LINE];

   logic                  data_we;
   logic [IX+WO-1:0]      data_waddr;
   logic [DATA_WIDTH-1:0] data_wdata;
   logic                  tag_we;

   logic [TW-1:0]         cpu_tag;
   logic [IX-1:0]         cpu_index;
   logic [WO-1:0]         cpu_word;
   logic [IX-1:0]         line_idx;
   logic                  hit;
   logic                  victim_dirty;
   logic                  flush_dirty;
   logic                  last_word;
   logic                  last_line;
   logic                  cpu_req;
   logic [DATA_WIDTH-1:0] hit_word;
   logic [DATA_WIDTH-1:0] wb_word;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [ADDR_WIDTH-1:0] rf_addr;

   assign cpu_tag   = cpu_address[ADDR_WIDTH-1 -: TW];
   assign cpu_index = cpu_address[BO+WO +: IX];
   assign cpu_word  = cpu_address[BO +: WO];

   generate
      if (BO > 0) begin : g_byte_off
         logic unused_byte_off;
         assign unused_byte_off = ^cpu_address[BO-1:0];
      end
   endgenerate

   // Writeback serves both the CPU victim and the flush scan line.
   assign line_idx     = flush_mode_q ? flush_idx_q : cpu_index;
   assign hit          = valid_q[cpu_index] && (tag_mem[cpu_index] == cpu_tag);
   assign victim_dirty = valid_q[cpu_index] && dirty_q[cpu_index];
   assign flush_dirty  = valid_q[flush_idx_q] && dirty_q[flush_idx_q];
   assign last_word    = (word_cnt_q == WO'(WORDS_PER_LINE - 1));
   assign last_line    = (flush_idx_q == IX'(NUM_LINES - 1));
   assign cpu_req      = cpu_read_enable || cpu_write_enable;
   assign hit_word     = data_mem[{cpu_index, cpu_word}];
   assign wb_word      = data_mem[{line_idx, word_cnt_q}];
   assign wb_addr      = ADDR_WIDTH'({tag_mem[line_idx], line_idx, word_cnt_q}) << BO;
   assign rf_addr      = ADDR_WIDTH'({cpu_tag, cpu_index, word_cnt_q}) << BO;

   always_ff @(posedge clk) begin
      if (data_we) begin
         data_mem[data_waddr] <= data_wdata;
      end
      if (tag_we) begin
         tag_mem[cpu_index] <= cpu_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         word_cnt_q   <= '0;
         flush_idx_q  <= '0;
         flush_mode_q <= 1'b0;
         valid_q      <= '0;
         dirty_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         flush_idx_q  <= flush_idx_d;
         flush_mode_q <= flush_mode_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         rdata_q      <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (flush_request) begin
               state_d = S_FLUSH;
            end else if (cpu_req) begin
               state_d = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (hit) begin
               state_d = S_IDLE;
            end else if (victim_dirty) begin
               state_d = S_WRITEBACK;
            end else begin
               state_d = S_REFILL;
            end
         end
         S_WRITEBACK: begin
            if (mem_ack && last_word) begin
               state_d = flush_mode_q ? S_FLUSH : S_REFILL;
            end
         end
         S_REFILL: begin
            if (mem_ack && last_word) begin
               state_d = S_COMPARE;
            end
         end
         S_FLUSH: begin
            if (flush_dirty) begin
               state_d = S_WRITEBACK;
            end else if (last_line) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cpu_ready        = 1'b0;
      cpu_read_data    = rdata_q;
      flush_done       = 1'b0;
      mem_address      = '0;
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      mem_write_data   = '0;
      rdata_d          = rdata_q;
      word_cnt_d       = word_cnt_q;
      flush_idx_d      = flush_idx_q;
      flush_mode_d     = flush_mode_q;
      valid_d          = valid_q;
      dirty_d          = dirty_q;
      data_we          = 1'b0;
      data_waddr       = {cpu_index, cpu_word};
      data_wdata       = cpu_write_data;
      tag_we           = 1'b0;
      case (state_q)
         S_IDLE: begin
            word_cnt_d = '0;
            if (flush_request) begin
               flush_mode_d = 1'b1;
               flush_idx_d  = '0;
            end
         end
         S_COMPARE: begin
            word_cnt_d = '0;
            if (hit) begin
               cpu_ready = 1'b1;
               if (cpu_write_enable) begin
                  data_we            = 1'b1;
                  dirty_d[cpu_index] = 1'b1;
               end else begin
                  cpu_read_data = hit_word;
                  rdata_d       = hit_word;
               end
            end else begin
               // Line is partly overwritten from here on, so it must not hit.
               valid_d[cpu_index] = 1'b0;
            end
         end
         S_WRITEBACK: begin
            mem_write_enable = 1'b1;
            mem_address      = wb_addr;
            mem_write_data   = wb_word;
            if (mem_ack) begin
               word_cnt_d = word_cnt_q + 1'b1;
               if (last_word) begin
                  dirty_d[line_idx] = 1'b0;
               end
            end
         end
         S_REFILL: begin
            mem_read_enable = 1'b1;
            mem_address     = rf_addr;
            if (mem_ack) begin
               data_we    = 1'b1;
               data_waddr = {cpu_index, word_cnt_q};
               data_wdata = mem_read_data;
               word_cnt_d = word_cnt_q + 1'b1;
               if (last_word) begin
                  valid_d[cpu_index] = 1'b1;
                  dirty_d[cpu_index] = 1'b0;
                  tag_we             = 1'b1;
               end
            end
         end
         S_FLUSH: begin
            word_cnt_d = '0;
            if (!flush_dirty) begin
               valid_d[flush_idx_q] = 1'b0;
               dirty_d[flush_idx_q] = 1'b0;
               if (last_line) begin
                  flush_done   = 1'b1;
                  flush_mode_d = 1'b0;
               end else begin
                  flush_idx_d = flush_idx_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

`ifdef CACHE_STATS_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;
   logic        refilled_q, refilled_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
         refilled_q   <= 1'b0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         refilled_q   <= refilled_d;
      end
   end

   // The compare that follows a refill is a guaranteed hit and is not counted.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      refilled_d   = refilled_q;
      if (state_q == S_IDLE) begin
         refilled_d = 1'b0;
      end else if (state_q == S_REFILL && mem_ack && last_word) begin
         refilled_d = 1'b1;
      end else if (state_q == S_COMPARE && !refilled_q) begin
         if (hit && hit_count_q != 32'hFFFF_FFFF) begin
            hit_count_d = hit_count_q + 32'd1;
         end else if (!hit && miss_count_q != 32'hFFFF_FFFF) begin
            miss_count_d = miss_count_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// tb/tb_cache_ctrl_wb.sv - directed self-checking bench for cache_ctrl_wb
// Memory responder acks each enabled word one cycle after it appears.

module tb_cache_ctrl_wb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] cpu_address;
   logic        cpu_read_enable;
   logic        cpu_write_enable;
   logic [31:0] cpu_write_data;
   logic [31:0] cpu_read_data;
   logic        cpu_ready;
   logic        flush_request;
   logic        flush_done;
   logic [31:0] mem_address;
   logic        mem_read_enable;
   logic        mem_write_enable;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic        mem_ack;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int tests = 0;
   int fails = 0;

   logic [31:0] backing [logic [31:0]];
   logic [31:0] rd_log[$];
   logic [31:0] wr_addr_log[$];
   logic [31:0] wr_data_log[$];

   cache_ctrl_wb dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cpu_address      (cpu_address),
      .cpu_read_enable  (cpu_read_enable),
      .cpu_write_enable (cpu_write_enable),
      .cpu_write_data   (cpu_write_data),
      .cpu_read_data    (cpu_read_data),
      .cpu_ready        (cpu_ready),
      .flush_request    (flush_request),
      .flush_done       (flush_done),
      .mem_address      (mem_address),
      .mem_read_enable  (mem_read_enable),
      .mem_write_enable (mem_write_enable),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data),
`ifdef CACHE_STATS_EN
      .hit_count        (hit_count),
      .miss_count       (miss_count),
`endif
      .mem_ack          (mem_ack)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (backing.exists(a)) return backing[a];
      return pat(a);
   endfunction

   always @(posedge clk) begin
      #1;
      if (!rst_n || mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_read_enable) begin
         mem_read_data = mem_rd(mem_address);
         rd_log.push_back(mem_address);
         mem_ack = 1'b1;
      end else if (mem_write_enable) begin
         backing[mem_address] = mem_write_data;
         wr_addr_log.push_back(mem_address);
         wr_data_log.push_back(mem_write_data);
         mem_ack = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst_n && (mem_read_enable || mem_write_enable)) begin
         tests++;
         assert (!(mem_read_enable && mem_write_enable)) else begin
            fails++;
            $error("FAIL both_enables: observed rd=%0b wr=%0b expected not both", mem_read_enable, mem_write_enable);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      rd_log.delete();
      wr_addr_log.delete();
      wr_data_log.delete();
   endtask

   task automatic cpu_op(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         output logic [31:0] rd, output int cyc);
      bit done;
      done = 1'b0;
      rd   = '0;
      cyc  = 0;
      @(posedge clk); #1;
      cpu_address      = a;
      cpu_write_enable = we;
      cpu_read_enable  = !we;
      cpu_write_data   = wd;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         if (cpu_ready) begin
            rd   = cpu_read_data;
            done = 1'b1;
         end
         @(posedge clk);
         cyc++;
      end
      #1;
      cpu_read_enable  = 1'b0;
      cpu_write_enable = 1'b0;
      chk("cpu_op_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      int          cyc;
      int          flush_at;
      int          ready_at;
      bit          early_ready;
      bit          found;

      rst_n            = 1'b0;
      cpu_address      = '0;
      cpu_read_enable  = 1'b0;
      cpu_write_enable = 1'b0;
      cpu_write_data   = '0;
      flush_request    = 1'b0;
      mem_read_data    = '0;
      mem_ack          = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      chk("rst_mem_rd_en", 32'(mem_read_enable), 32'd0);
      chk("rst_mem_wr_en", 32'(mem_write_enable), 32'd0);
      chk("rst_cpu_rdata", cpu_read_data, 32'd0);
      chk("rst_mem_addr", mem_address, 32'd0);
      chk("rst_mem_wdata", mem_write_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Cold read miss: refill of the whole line, word 0 returned
      clear_logs();
      cpu_op(32'h0000_0010, 1'b0, '0, rd, cyc);
      chk("cold_rdata", rd, 32'h5A5A_0010);
      chk("cold_nreads", 32'(rd_log.size()), 32'd4);
      chk("cold_nwrites", 32'(wr_addr_log.size()), 32'd0);
      for (int i = 0; i < 4 && i < rd_log.size(); i++)
         chk("cold_raddr", rd_log[i], 32'h10 + 32'(4 * i));

      // Repeat read hit: two cycles, no memory traffic
      clear_logs();
      cpu_op(32'h0000_0014, 1'b0, '0, rd, cyc);
      chk("hit_rdata", rd, 32'h5A5A_0014);
      chk("hit_latency", 32'(cyc), 32'd2);
      chk("hit_nmem", 32'(rd_log.size() + wr_addr_log.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rdata_hold", cpu_read_data, 32'h5A5A_0014);

      // Write hit then conflicting read: writeback of the dirty victim, then refill
      cpu_op(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, rd, cyc);
      chk("wr_hit_latency", 32'(cyc), 32'd2);
      clear_logs();
      cpu_op(32'h0000_1010, 1'b0, '0, rd, cyc);
      chk("conf_nwrites", 32'(wr_addr_log.size()), 32'd4);
      chk("conf_nreads", 32'(rd_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < wr_addr_log.size(); i++)
         chk("conf_waddr", wr_addr_log[i], 32'h10 + 32'(4 * i));
      if (wr_data_log.size() >= 2) begin
         chk("conf_wdata0", wr_data_log[0], 32'hDEAD_BEEF);
         chk("conf_wdata1", wr_data_log[1], 32'h5A5A_0014);
      end
      for (int i = 0; i < 4 && i < rd_log.size(); i++)
         chk("conf_raddr", rd_log[i], 32'h1010 + 32'(4 * i));
      chk("conf_rdata", rd, 32'h5A5A_1010);

      // Flush with a single dirty line at index 5
      cpu_op(32'h0000_0058, 1'b1, 32'h1234_5678, rd, cyc);
      clear_logs();
      @(posedge clk); #1;
      flush_request = 1'b1;
      @(posedge clk); #1;
      flush_request = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (flush_done) found = 1'b1;
      end
      chk("flush_done_seen", 32'(found), 32'd1);
      @(negedge clk);
      chk("flush_done_pulse", 32'(flush_done), 32'd0);
      chk("flush_nwrites", 32'(wr_addr_log.size()), 32'd4);
      chk("flush_nreads", 32'(rd_log.size()), 32'd0);
      for (int i = 0; i < 4 && i < wr_addr_log.size(); i++)
         chk("flush_waddr", wr_addr_log[i], 32'h50 + 32'(4 * i));
      if (wr_data_log.size() >= 3)
         chk("flush_wdata2", wr_data_log[2], 32'h1234_5678);
      clear_logs();
      cpu_op(32'h0000_0058, 1'b0, '0, rd, cyc);
      chk("postflush_nreads", 32'(rd_log.size()), 32'd4);
      chk("postflush_rdata", rd, 32'h1234_5678);

      // Flush and read in the same cycle: flush wins, read completes afterwards
      clear_logs();
      @(posedge clk); #1;
      flush_request   = 1'b1;
      cpu_address     = 32'h0000_1010;
      cpu_read_enable = 1'b1;
      @(posedge clk); #1;
      flush_request = 1'b0;
      flush_at    = 0;
      ready_at    = 0;
      early_ready = 1'b0;
      for (int i = 1; i < 2000 && ready_at == 0; i++) begin
         @(negedge clk);
         if (flush_done && flush_at == 0) flush_at = i;
         if (cpu_ready) begin
            if (flush_at == 0) early_ready = 1'b1;
            ready_at = i;
            rd = cpu_read_data;
         end
      end
      @(posedge clk); #1;
      cpu_read_enable = 1'b0;
      chk("both_flush_seen", 32'(flush_at != 0), 32'd1);
      chk("both_ready_seen", 32'(ready_at != 0), 32'd1);
      chk("both_early_ready", 32'(early_ready), 32'd0);
      chk("both_order", 32'(ready_at > flush_at), 32'd1);
      chk("both_nwrites", 32'(wr_addr_log.size()), 32'd0);
      chk("both_rdata", rd, 32'h5A5A_1010);

      // Reset during refill word 2
      @(posedge clk); #1;
      cpu_address     = 32'h0000_0208;
      cpu_read_enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (mem_read_enable && mem_address == 32'h0000_0208) found = 1'b1;
      end
      chk("rst_mid_found", 32'(found), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_rd_en", 32'(mem_read_enable), 32'd0);
      chk("rst_mid_wr_en", 32'(mem_write_enable), 32'd0);
      chk("rst_mid_ready", 32'(cpu_ready), 32'd0);
      chk("rst_mid_addr", mem_address, 32'd0);
      cpu_read_enable = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
      cpu_op(32'h0000_0208, 1'b0, '0, rd, cyc);
      chk("rst_after_nreads", 32'(rd_log.size()), 32'd4);
      if (rd_log.size() > 0)
         chk("rst_after_raddr0", rd_log[0], 32'h0000_0200);
      chk("rst_after_rdata", rd, 32'h5A5A_0208);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
